// File: rtl/os_seq_if.sv
// rtl/os_seq_if.sv - handshake and instruction bundle between os_inst_sequencer and the core
interface os_seq_if;
    logic        start;
    logic        l0_ready;
    logic        ififo_ready;
    logic        ofifo_valid;
    logic [40:0] inst;
    logic        busy;
    logic        done;

    modport master (
        input  start, l0_ready, ififo_ready, ofifo_valid,
        output inst, busy, done
    );

    modport slave (
        output start, l0_ready, ififo_ready, ofifo_valid,
        input  inst, busy, done
    );
endinterface

// File: rtl/os_inst_sequencer.sv
// rtl/os_inst_sequencer.sv - per-tile instruction generator for the output-stationary core
// Define OS_SEQ_MAXPOOL_EN to drive max_pool_en (inst[40]) alongside every drain read.
module os_inst_sequencer #(
    parameter int         LEN_NIJ   = 27,
    parameter int         SHIFT_LEN = 16,
    parameter int         NUM_OUT   = 8,
    parameter logic [7:0] W_BASE    = 8'h80
) (
    input  logic      clk,
    input  logic      reset,
    os_seq_if.master  bus
);
    localparam int CW = $clog2(LEN_NIJ + 1);
    localparam int PW = $clog2(SHIFT_LEN + NUM_OUT + 4);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_FLUSH = 3'd2,
        S_SHIFT = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   ph_q;
    logic            issue, rd_fire, last_rd;

    logic            iss_q, wr_q, rd_q, ex_q, ld_q, mode_q, ofrd_q, mp_q, done_q, busy_q;
    logic            iss_d, wr_d, rd_d, ex_d, ld_d, mode_d, ofrd_d, mp_d, done_d, busy_d;
    logic [7:0]      a0_q, a1_q, a0_d, a1_d;

    assign issue   = (state_q == S_EXEC) && bus.l0_ready && bus.ififo_ready;
    assign rd_fire = (state_q == S_DRAIN) && bus.ofifo_valid;
    assign last_rd = rd_fire && (ph_q == PW'(NUM_OUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start && !busy_q)                          state_d = S_EXEC;
            S_EXEC:  if (issue && (cnt_q == CW'(LEN_NIJ - 1)))          state_d = S_FLUSH;
            S_FLUSH: if (ph_q == PW'(2))                                state_d = S_SHIFT;
            S_SHIFT: if (ph_q == PW'(SHIFT_LEN - 1))                    state_d = S_DRAIN;
            S_DRAIN: if (last_rd)                                       state_d = S_IDLE;
            default:                                                    state_d = S_IDLE;
        endcase
    end

    // ph_q counts cycles in FLUSH/SHIFT and accepted reads in DRAIN; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset || state_q == S_IDLE) cnt_q <= '0;
        else if (issue)                 cnt_q <= cnt_q + CW'(1);

        if (reset || state_d != state_q)
            ph_q <= '0;
        else if (state_q == S_FLUSH || state_q == S_SHIFT || rd_fire)
            ph_q <= ph_q + PW'(1);
    end

    always_comb begin
        a0_d = a0_q;
        a1_d = a1_q;
        if (issue) begin
            a0_d = 8'(cnt_q);
            a1_d = W_BASE + 8'(cnt_q);
        end else if (state_d == S_IDLE) begin
            a0_d = 8'h00;
            a1_d = 8'h00;
        end
        // Issue strobe ripples through write, read and execute stages; stalls become bubbles.
        iss_d  = issue;
        wr_d   = iss_q;
        rd_d   = wr_q;
        ex_d   = rd_q;
        ld_d   = (state_q == S_SHIFT);
        mode_d = rd_q | ld_d;
        ofrd_d = rd_fire;
        done_d = last_rd;
        busy_d = (state_d != S_IDLE) || last_rd;
`ifdef OS_SEQ_MAXPOOL_EN
        mp_d   = rd_fire;
`else
        mp_d   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_q  <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            ex_q   <= 1'b0;
            ld_q   <= 1'b0;
            mode_q <= 1'b0;
            ofrd_q <= 1'b0;
            mp_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            a0_q   <= 8'h00;
            a1_q   <= 8'h00;
        end else begin
            iss_q  <= iss_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ex_q   <= ex_d;
            ld_q   <= ld_d;
            mode_q <= mode_d;
            ofrd_q <= ofrd_d;
            mp_q   <= mp_d;
            done_q <= done_d;
            busy_q <= busy_d;
            a0_q   <= a0_d;
            a1_q   <= a1_d;
        end
    end

    assign bus.inst = {mp_q, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0,
                       ~iss_q, a1_q,
                       ~iss_q, 1'b1, a0_q,
                       ofrd_q, wr_q, rd_q, rd_q, wr_q, mode_q, ex_q, ld_q};
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_os_inst_sequencer.sv
// tb/tb_os_inst_sequencer.sv - event-schedule model plus directed tiles for os_inst_sequencer
module tb_os_inst_sequencer;
    localparam int N      = 2048;
    localparam int LEN    = 27;
    localparam int NOUT   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    os_seq_if bus ();

    os_inst_sequencer dut (.clk(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected output of every cycle, filled in ahead of time as the model makes decisions.
    bit       e_iss  [0:N-1];
    bit       e_wr   [0:N-1];
    bit       e_rd   [0:N-1];
    bit       e_ex   [0:N-1];
    bit       e_ld   [0:N-1];
    bit       e_ofrd [0:N-1];
    bit       e_done [0:N-1];
    bit       e_busy [0:N-1];
    bit [7:0] e_a0   [0:N-1];

    bit active = 0;
    int issued = 0, reads = 0, drain_from = 0, cyc = 0;

    int n_iss, n_ex, n_ld, n_ofrd, n_done;
    int first_a0, last_a0, t_iss0, t_ex0, t_exl, t_ld0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic clr_tally();
        n_iss = 0; n_ex = 0; n_ld = 0; n_ofrd = 0; n_done = 0;
        first_a0 = -1; last_a0 = -1; t_iss0 = -1; t_ex0 = -1; t_exl = -1; t_ld0 = -1;
    endtask

    task automatic compare(input int n);
        logic [40:0] exp, act;
        bit addr_known;
        exp = '0;
        exp[37] = 1'b1; exp[36] = 1'b1; exp[16] = 1'b1;
        exp[26] = !e_iss[n]; exp[17] = !e_iss[n];
        if (e_iss[n]) begin
            exp[15:8]  = e_a0[n];
            exp[25:18] = 8'h80 + e_a0[n];
        end
        exp[7] = e_ofrd[n];
        exp[6] = e_wr[n]; exp[3] = e_wr[n];
        exp[5] = e_rd[n]; exp[4] = e_rd[n];
        exp[2] = e_ex[n] | e_ld[n];
        exp[1] = e_ex[n];
        exp[0] = e_ld[n];
`ifdef OS_SEQ_MAXPOOL_EN
        exp[40] = e_ofrd[n];
`endif
        act = bus.inst;
        addr_known = e_iss[n] || !e_busy[n];
        if (!addr_known) begin
            act[25:18] = 8'h00; act[15:8] = 8'h00;
            exp[25:18] = 8'h00; exp[15:8] = 8'h00;
        end
        check("inst", 64'(act), 64'(exp));
        check("busy", 64'(bus.busy), 64'(e_busy[n]));
        check("done", 64'(bus.done), 64'(e_done[n]));

        if (!bus.inst[17]) begin
            if (n_iss == 0) begin first_a0 = int'(bus.inst[15:8]); t_iss0 = n; end
            last_a0 = int'(bus.inst[15:8]);
            n_iss++;
        end
        if (bus.inst[1]) begin
            if (n_ex == 0) t_ex0 = n;
            t_exl = n;
            n_ex++;
        end
        if (bus.inst[0]) begin
            if (n_ld == 0) t_ld0 = n;
            n_ld++;
        end
        if (bus.inst[7]) n_ofrd++;
        if (bus.done)    n_done++;
    endtask

    // Decides, from the inputs about to be sampled, what the following cycles must show.
    task automatic model_step(input int n);
        if (rst) begin
            for (int i = n + 1; i < N; i++) begin
                e_iss[i] = 0; e_wr[i] = 0; e_rd[i] = 0; e_ex[i] = 0; e_ld[i] = 0;
                e_ofrd[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_a0[i] = 8'h00;
            end
            active = 0; issued = 0; reads = 0;
        end else begin
            if (!active && !e_busy[n] && bus.start) begin
                active = 1; issued = 0; reads = 0;
            end else if (active) begin
                if (issued < LEN) begin
                    if (bus.l0_ready && bus.ififo_ready) begin
                        e_iss[n+1] = 1; e_a0[n+1] = 8'(issued);
                        e_wr[n+2] = 1; e_rd[n+3] = 1; e_ex[n+4] = 1;
                        issued++;
                        if (issued == LEN) begin
                            for (int j = 5; j <= 20; j++) e_ld[n+j] = 1;
                            drain_from = n + 20;
                        end
                    end
                end else if (n >= drain_from && bus.ofifo_valid) begin
                    e_ofrd[n+1] = 1;
                    reads++;
                    if (reads == NOUT) begin
                        e_done[n+1] = 1;
                        e_busy[n+1] = 1;
                        active = 0;
                    end
                end
            end
            if (active) e_busy[n+1] = 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc < N - 32) begin
                compare(cyc);
                model_step(cyc);
            end
            cyc++;
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) step(1);
        check({name, "_done_seen"}, 64'(n_done > 0), 64'd1);
        step(3);
    endtask

    task automatic tile_literals(input string name);
        check({name, "_issues"},   64'(n_iss), 64'd27);
        check({name, "_executes"}, 64'(n_ex), 64'd27);
        check({name, "_loads"},    64'(n_ld), 64'd16);
        check({name, "_reads"},    64'(n_ofrd), 64'd8);
        check({name, "_dones"},    64'(n_done), 64'd1);
        check({name, "_first_a0"}, 64'(first_a0), 64'h00);
        check({name, "_last_a0"},  64'(last_a0), 64'h1a);
        check({name, "_ld_after_ex"}, 64'(t_ld0 - t_exl), 64'd1);
    endtask

    initial begin
        bus.start = 1'b0; bus.l0_ready = 1'b1; bus.ififo_ready = 1'b1; bus.ofifo_valid = 1'b1;
        clr_tally();
        step(3);
        rst = 1'b0;

        // Idle after reset: nothing may move.
        step(10);
        check("idle_dones", 64'(n_done), 64'd0);
        check("idle_issues", 64'(n_iss), 64'd0);

        // Free-running tile.
        clr_tally();
        pulse_start();
        wait_done("free", 200);
        tile_literals("free");
        check("free_first_ex_latency", 64'(t_ex0 - t_iss0), 64'd3);

        // IFIFO stall during EXEC cycles 5..8.
        clr_tally();
        pulse_start();
        step(3);
        bus.ififo_ready = 1'b0;
        step(4);
        bus.ififo_ready = 1'b1;
        wait_done("stall", 200);
        tile_literals("stall");

        // OFIFO valid pattern 1,1,0,1x6 during DRAIN.
        clr_tally();
        bus.ofifo_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 200 && n_ld < 16; i++) step(1);
        check("pat_shift_seen", 64'(n_ld), 64'd16);
        begin
            bit [8:0] pat;
            pat = 9'b111111011;
            for (int i = 0; i < 9; i++) begin
                bus.ofifo_valid = pat[i];
                step(1);
            end
        end
        bus.ofifo_valid = 1'b1;
        wait_done("pat", 20);
        tile_literals("pat");

        // Reset in the middle of SHIFT, then a clean replay.
        clr_tally();
        pulse_start();
        for (int i = 0; i < 200 && n_ld < 5; i++) step(1);
        check("rst_shift_seen", 64'(n_ld >= 5), 64'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_load",  64'(bus.inst[0]), 64'd0);
        check("rst_mode",  64'(bus.inst[2]), 64'd0);
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_dones", 64'(n_done), 64'd0);
        step(2);
        clr_tally();
        pulse_start();
        wait_done("replay", 200);
        tile_literals("replay");

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
